// File: rtl/i2s_dac_transmitter_if.sv
// Sample handshake bundle between a PCM source and the I2S DAC transmitter.
// The source owns the stereo pair and valid; the transmitter answers with ready.
interface i2s_dac_transmitter_if #(
    parameter int DATA_WIDTH = 24
) ();
    logic [DATA_WIDTH-1:0] left_in;
    logic [DATA_WIDTH-1:0] right_in;
    logic                  sample_valid;
    logic                  sample_ready;

    modport master (output left_in, right_in, sample_valid, input sample_ready);
    modport slave  (input left_in, right_in, sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_dac_transmitter.sv
// I2S slave transmitter for the WM8731 DAC pin: buffers stereo pairs in a small
// FIFO and shifts them out MSB first on the codec's BCLK/LRCK, with underflow silence.
module i2s_dac_transmitter #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    i2s_dac_transmitter_if.slave        s_if,
    input  logic                        AUD_BCLK,
    input  logic                        AUD_DACLRCK,
    output logic                        AUD_DACDAT,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 underflow_count
);
    localparam int CW = $clog2(SLOT_WIDTH);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    logic                  bclk_meta_q, bclk_sync_q, bclk_prev_q;
    logic                  lrck_meta_q, lrck_sync_q, lr_last_q;
    logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q;

    state_t                state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  dacdat_q, dacdat_d;
    logic [15:0]           uf_q, uf_d;

    logic                  fe, boundary, to_left, to_right;
    logic                  fifo_empty, fifo_full, ready, push, pop;
    logic [2*DATA_WIDTH-1:0] head;
    logic [CW-1:0]         cnt_inc;

    assign fe         = bclk_prev_q & ~bclk_sync_q;
    assign boundary   = fe & (lrck_sync_q != lr_last_q);
    assign to_left    = boundary & ~lrck_sync_q;
    assign to_right   = boundary & lrck_sync_q;
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
    assign ready      = ~fifo_full & ~reset;
    assign push       = s_if.sample_valid & ready;
    // Pop decision uses the registered level, so a same-cycle push never bypasses.
    assign pop        = to_left & ~fifo_empty;
    assign head       = mem_q[rd_ptr_q];
    assign cnt_inc    = (bit_cnt_q == CW'(SLOT_WIDTH - 1)) ? bit_cnt_q : bit_cnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        hold_d    = hold_q;
        dacdat_d  = dacdat_q;
        uf_d      = uf_q;
        if (fe) begin
            dacdat_d  = 1'b0;
            bit_cnt_d = boundary ? '0 : cnt_inc;
        end
        if (to_left) begin
            state_d = LEFT;
            if (fifo_empty) begin
                shift_d = '0;
                hold_d  = '0;
                if (uf_q != 16'hFFFF) uf_d = uf_q + 16'd1;
            end else begin
                shift_d = head[2*DATA_WIDTH-1:DATA_WIDTH];
                hold_d  = head[DATA_WIDTH-1:0];
            end
        end else if (to_right) begin
            if (state_q == LEFT) begin
                state_d = RIGHT;
                shift_d = hold_q;
            end
        end else if (fe && state_q != IDLE && cnt_inc <= CW'(DATA_WIDTH)) begin
            dacdat_d = shift_q[DATA_WIDTH-1];
            shift_d  = {shift_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_meta_q <= 1'b0;
            bclk_sync_q <= 1'b0;
            bclk_prev_q <= 1'b0;
            lrck_meta_q <= 1'b0;
            lrck_sync_q <= 1'b0;
            lr_last_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            dacdat_q    <= 1'b0;
            uf_q        <= '0;
        end else begin
            bclk_meta_q <= AUD_BCLK;
            bclk_sync_q <= bclk_meta_q;
            bclk_prev_q <= bclk_sync_q;
            lrck_meta_q <= AUD_DACLRCK;
            lrck_sync_q <= lrck_meta_q;
            if (fe) lr_last_q <= lrck_sync_q;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            dacdat_q  <= dacdat_d;
            uf_q      <= uf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {s_if.left_in, s_if.right_in};
    end

    assign s_if.sample_ready = ready;
    assign AUD_DACDAT        = dacdat_q;
    assign fifo_level        = level_q;
    assign underflow_count   = uf_q;
endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// Directed bench for the I2S DAC transmitter: frame vectors from a table, then
// hand-written sequences for full-FIFO pop, short slot and mid-word reset.
module tb_i2s_dac_transmitter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        AUD_BCLK = 1'b1;
    logic        AUD_DACLRCK = 1'b0;
    logic        AUD_DACDAT;
    logic [2:0]  fifo_level;
    logic [15:0] underflow_count;

    int n_tests = 0;
    int n_fail  = 0;

    i2s_dac_transmitter_if #(.DATA_WIDTH(24)) s_if ();

    i2s_dac_transmitter #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .s_if            (s_if),
        .AUD_BCLK        (AUD_BCLK),
        .AUD_DACLRCK     (AUD_DACLRCK),
        .AUD_DACDAT      (AUD_DACDAT),
        .fifo_level      (fifo_level),
        .underflow_count (underflow_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [23:0] l;
        logic [23:0] r;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
        logic [15:0] exp_uf;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One BCLK period (8 clk low, 8 clk high); DACDAT is sampled late in the low phase.
    task automatic bclk_bit(input logic lr, output logic b);
        @(negedge clk);
        AUD_DACLRCK = lr;
        AUD_BCLK    = 1'b0;
        repeat (8) @(negedge clk);
        b = AUD_DACDAT;
        AUD_BCLK = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_slot(input logic lr, input int nbits, output logic [63:0] word);
        logic b;
        word = '0;
        for (int i = 0; i < nbits; i++) begin
            bclk_bit(lr, b);
            word = {word[62:0], b};
        end
    endtask

    task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
        int k;
        @(negedge clk);
        s_if.left_in      = l;
        s_if.right_in     = r;
        s_if.sample_valid = 1'b1;
        k = 0;
        while (!s_if.sample_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) check("push_timeout", 64'(s_if.sample_ready), 64'd1);
        @(negedge clk);
        s_if.sample_valid = 1'b0;
        $display("[TB] push L=%06h R=%06h level=%0d", l, r, fifo_level);
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] w;
        logic        saw3;

        vecs[0] = '{1'b1, 24'hABCDEF, 24'h123456, 32'h55E6F780, 32'h091A2B00, 16'd0};
        vecs[1] = '{1'b1, 24'hFFFFFF, 24'h000000, 32'h7FFFFF80, 32'h00000000, 16'd0};
        vecs[2] = '{1'b1, 24'h800001, 24'h7FFFFE, 32'h40000080, 32'h3FFFFF00, 16'd0};
        vecs[3] = '{1'b0, 24'h000000, 24'h000000, 32'h00000000, 32'h00000000, 16'd1};
        vecs[4] = '{1'b0, 24'h000000, 24'h000000, 32'h00000000, 32'h00000000, 16'd2};
        vecs[5] = '{1'b0, 24'h000000, 24'h000000, 32'h00000000, 32'h00000000, 16'd3};

        s_if.left_in      = '0;
        s_if.right_in     = '0;
        s_if.sample_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", 64'(s_if.sample_ready), 64'd0);
        check("rst_dacdat", 64'(AUD_DACDAT), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_uf", 64'(underflow_count), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(s_if.sample_ready), 64'd1);

        // Right slot straight after reset must be ignored.
        send_slot(1'b1, 32, w);
        check("idle_right_silent", w, 64'd0);
        $display("[TB] lead-in right slot word=%08h", w[31:0]);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].push) push_pair(vecs[v].l, vecs[v].r);
            check("vec_level_pre", 64'(fifo_level), 64'(vecs[v].push));
            send_slot(1'b0, 32, w);
            check("vec_left_word", w, 64'(vecs[v].exp_l));
            check("vec_level_post", 64'(fifo_level), 64'd0);
            send_slot(1'b1, 32, w);
            check("vec_right_word", w, 64'(vecs[v].exp_r));
            check("vec_uf", 64'(underflow_count), 64'(vecs[v].exp_uf));
            $display("[TB] frame %0d push=%0d L=%06h R=%06h uf=%0d", v, vecs[v].push,
                     vecs[v].l, vecs[v].r, underflow_count);
        end

        // Fill the FIFO with BCLK held.
        push_pair(24'h5A5A5A, 24'h0F0F0F);
        check("fill_level1", 64'(fifo_level), 64'd1);
        push_pair(24'hFFFFFF, 24'h123456);
        check("fill_level2", 64'(fifo_level), 64'd2);
        push_pair(24'h800001, 24'h7FFFFE);
        check("fill_level3", 64'(fifo_level), 64'd3);
        push_pair(24'h111111, 24'h222222);
        check("fill_level4", 64'(fifo_level), 64'd4);
        check("fill_ready_low", 64'(s_if.sample_ready), 64'd0);

        @(negedge clk);
        s_if.left_in      = 24'h333333;
        s_if.right_in     = 24'h444444;
        s_if.sample_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("fifth_held_level", 64'(fifo_level), 64'd4);
        check("fifth_held_ready", 64'(s_if.sample_ready), 64'd0);

        // Left boundary while full with a push pending.
        @(negedge clk);
        AUD_DACLRCK = 1'b0;
        AUD_BCLK    = 1'b0;
        saw3 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (fifo_level == 3'd3) saw3 = 1'b1;
        end
        check("full_pop_level3", 64'(saw3), 64'd1);
        check("full_pop_push_next", 64'(fifo_level), 64'd4);
        check("full_pop_delay_bit", 64'(AUD_DACDAT), 64'd0);
        s_if.sample_valid = 1'b0;
        AUD_BCLK = 1'b1;
        repeat (8) @(negedge clk);
        $display("[TB] full-fifo pop with pending push, level=%0d", fifo_level);

        send_slot(1'b0, 31, w);
        check("p1_left_rest", w, 64'h2D2D2D00);
        send_slot(1'b1, 32, w);
        check("p1_right", w, 64'h07878780);
        check("p1_uf", 64'(underflow_count), 64'd3);

        // Short left slot: 16 BCLK with an all-ones sample.
        send_slot(1'b0, 16, w);
        check("short_left", w, 64'h7FFF);
        send_slot(1'b1, 32, w);
        check("short_then_right", w, 64'h091A2B00);
        check("short_uf", 64'(underflow_count), 64'd3);
        check("short_level", 64'(fifo_level), 64'd3);
        $display("[TB] short slot left=%04h right=%08h", 16'hFFFF & w[15:0], w[31:0]);

        // Reset part-way through the left word with two pairs queued.
        send_slot(1'b0, 10, w);
        check("pre_rst_bits", w, 64'h100);
        check("pre_rst_level", 64'(fifo_level), 64'd2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 64'(s_if.sample_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_dacdat", 64'(AUD_DACDAT), 64'd0);
        check("mid_rst_level", 64'(fifo_level), 64'd0);
        check("mid_rst_uf", 64'(underflow_count), 64'd0);
        check("mid_rst_ready_after", 64'(s_if.sample_ready), 64'd1);
        send_slot(1'b0, 22, w);
        check("rst_left_rest", w, 64'd0);
        send_slot(1'b1, 32, w);
        check("rst_right_ignored", w, 64'd0);
        check("rst_right_uf", 64'(underflow_count), 64'd0);
        send_slot(1'b0, 32, w);
        check("rst_left_silence", w, 64'd0);
        check("rst_left_uf", 64'(underflow_count), 64'd1);
        send_slot(1'b1, 32, w);
        check("rst_right_silence", w, 64'd0);
        $display("[TB] mid-word reset, uf=%0d level=%0d", underflow_count, fifo_level);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_dac_transmitter.md
# i2s_dac_transmitter

Serializes stereo PCM samples onto the WM8731 DAC data pin in I2S format. It is the transmit-direction counterpart of the ADC capture path. The codec is bit-clock and LR-clock master; this block is slave and samples AUD_BCLK and AUD_DACLRCK in the 50 MHz domain. Samples arrive through a valid/ready handshake into a small FIFO, one stereo pair per frame. If no pair is available at a frame start, the block plays silence and counts the underflow.

## Interface
Parameters:
- DATA_WIDTH, 24: bits per channel sample, MSB first. Must be at most SLOT_WIDTH-1.
- SLOT_WIDTH, 32: maximum BCLK periods per channel slot; sets the bit counter range.
- FIFO_DEPTH, 4: stereo pairs buffered. Power of two, 2 or more.

Ports:
- clk, input, 1: 50 MHz system clock.
- reset, input, 1: one clock; reset is synchronous and active-high.
- left_in, input, DATA_WIDTH: left sample, two's complement.
- right_in, input, DATA_WIDTH: right sample.
- sample_valid, input, 1: left_in/right_in hold a pair.
- sample_ready, output, 1: FIFO can accept a pair. A pair is pushed on a clk edge where valid && ready.
- AUD_BCLK, input, 1: codec bit clock, asynchronous.
- AUD_DACLRCK, input, 1: codec LR clock, asynchronous. 0 = left slot, 1 = right slot.
- AUD_DACDAT, output, 1: serial data, registered.
- fifo_level, output, $clog2(FIFO_DEPTH)+1: pairs currently stored.
- underflow_count, output, 16: frames sent as silence. Saturates at 0xFFFF.

## Operation
- Synchronizers: AUD_BCLK and AUD_DACLRCK each pass through two flops, plus a third "previous" flop.
  - BCLK falling edge (fe) = prev && !sync.
  - LRCK is sampled only on fe into lr_last.
- Channel boundary: at an fe where the synchronized LRCK differs from lr_last.
- Per-slot bit counter, range 0..SLOT_WIDTH-1, saturating. It is cleared at each boundary.
  - At the boundary fe, drive 0. This is the I2S one-bit delay.
  - Counter 1..DATA_WIDTH: drive shift[DATA_WIDTH-1] and shift left.
  - Beyond DATA_WIDTH: drive 0.
- FSM states: IDLE, LEFT, RIGHT.
  - IDLE: DACDAT=0. Go to LEFT only on a boundary whose new LRCK=0. A boundary into RIGHT while in IDLE is ignored, so no partial frame is sent after reset.
  - Boundary into LEFT, from any state: pop the FIFO head.
    - If the FIFO is non-empty: shift←left, hold←right.
    - If empty: shift←0, hold←0, underflow_count+1 (saturating). The state still goes to LEFT.
  - Boundary into RIGHT, from LEFT: shift←hold. Go to RIGHT.
- Short slot: if LRCK toggles before DATA_WIDTH bits are sent, the remaining bits are dropped and the new slot starts normally.
- Long slot: extra BCLKs output 0.
- FIFO:
  - Push when sample_valid && sample_ready.
  - sample_ready = !full && !reset, computed from the registered level.
  - When full and a pop happens in the same cycle: the pop occurs, ready stays 0, and no push happens that cycle.
  - Push into empty with a pop in the same cycle: no bypass. The pop sees empty, so underflow is recorded and the pushed pair remains stored.
  - fifo_level changes by +1, -1 or 0 (simultaneous push and pop) per clk.
- Reset mid-operation takes effect at the next clk edge:
  - FIFO is emptied.
  - State goes to IDLE, AUD_DACDAT goes to 0, counters are cleared.
  - The in-flight word is discarded.
  - Synchronizer flops are also cleared.

## Timing
- Reset values: AUD_DACDAT=0, sample_ready=0 while reset is high (1 on the first cycle after, since the FIFO is empty), fifo_level=0, underflow_count=0, state IDLE.
- Pin-to-output latency: AUD_DACDAT updates on the 3rd clk rising edge after AUD_BCLK's falling edge is first sampled.
  - Each BCLK phase must be at least 4 clk. This holds at 48 kHz × 64 BCLK (about 8 clk per phase).
- Pop, underflow increment and fifo_level update occur on the same clk as the boundary fe.
- Push is visible in fifo_level one clk after the handshake edge.

## Test plan
- Push L=0xABCDEF, R=0x123456, then run 64 BCLK per frame with LRCK starting at 0.
  - Left slot: 0, then bits 101010111100110111101111, then 7 zeros.
  - Right slot: 0, then 000100100011010001010110, then 7 zeros.
  - fifo_level goes 1→0 at the left boundary.
- FIFO empty for 3 frames: DACDAT stays all 0 and underflow_count = 3.
- Push 5 pairs with BCLK held: sample_ready falls after the 4th push, fifo_level=4, and the 5th pair is held off until a pop.
- Full FIFO with a push attempt on the same clk as a left boundary: level becomes 3, no push that cycle, and the push is accepted the next cycle (level 4).
- LRCK toggles after 16 BCLK in the left slot with L=0xFFFFFF: 15 ones are sent, then the right word starts with its delay bit. No underflow is recorded.
- Assert reset for 1 clk midway through the left word with 2 pairs queued:
  - DACDAT=0, level=0, underflow_count=0.
  - A subsequent right boundary is ignored.
  - The next left boundary with an empty FIFO sends silence and sets underflow_count=1.
